// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the flip-flop bank arbiter.
package dff_bank_arbiter_pkg;

    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_N         = 8;
    localparam int MAX_IDW       = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] idx;
    } pick_t;

    // First set bit of vec scanning upward from ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]   vec,
                                      input logic [MAX_IDW-1:0] ptr,
                                      input int unsigned        n);
        pick_t              r;
        logic [MAX_IDW-1:0] cand;
        r = '0;
        for (int unsigned off = 0; off < MAX_N; off++) begin
            cand = MAX_IDW'((32'(ptr) + off) % n);
            if (!r.valid && off < n && vec[cand]) begin
                r.valid = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_dff_reg.sv
// Shared WIDTH-bit storage register with synchronous reset and load enable.
module dff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

    assign qbar = ~q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared register,
// with an optional lock that keeps ownership across back-to-back writes.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       lock,
    input  logic [N*WIDTH-1:0] wdata,
    output logic [N-1:0]       gnt,
    output logic [IDW-1:0]     owner,
    output logic               busy,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   Qbar
);

    state_t         state, state_next;
    logic [N-1:0]   eligible, gnt_next;
    logic [IDW-1:0] rr_ptr, ptr_next, owner_next, sel, k;
    pick_t          pick;

    // Mask the current grantee so a req still held on its grant cycle is not re-granted.
    assign eligible = req & ~gnt;
    assign pick     = rr_pick(MAX_N'(eligible), MAX_IDW'(rr_ptr), N);
    assign k        = IDW'(pick.idx);
    assign busy     = (state == LOCKED);

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: default every comb output first so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (pick.valid && lock[k]) state_next = LOCKED;
            LOCKED:  if (!req[owner] || !lock[owner]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_next   = '0;
        sel        = owner;
        owner_next = owner;
        ptr_next   = rr_ptr;
        case (state)
            IDLE: begin
                if (pick.valid) begin
                    gnt_next[k] = 1'b1;
                    sel         = k;
                    owner_next  = k;
                    ptr_next    = (k == IDW'(N-1)) ? '0 : k + 1'b1;
                end
            end
            LOCKED: begin
                if (req[owner]) gnt_next[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            gnt    <= gnt_next;
            owner  <= owner_next;
            rr_ptr <= ptr_next;
        end
    end

    // The register loads on the same edge that raises gnt.
    dff_reg #(.WIDTH(WIDTH)) u_reg (
        .clk  (clk),
        .reset(reset),
        .en   (|gnt_next),
        .d    (wdata[sel*WIDTH +: WIDTH]),
        .q    (Q),
        .qbar (Qbar)
    );

endmodule
